pmem_burst_bridge: RTL and testbench

Responder for the 256-bit line interface (pmem_read/pmem_write/pmem_address/pmem_wdata → pmem_resp/pmem_rdata) that the L1 cache group and arbiter drive. Each line request is converted into a 4-beat, 64-bit burst on the narrow physical-memory port, and one pmem_resp is returned per line. The bridge sits between the arbiter output and the off-chip memory model/controller.

---
 rtl/pmem_burst_bridge_pkg.sv | 31 +++
 rtl/pmem_burst_bridge_if.sv | 46 ++++
 rtl/pmem_burst_bridge_line_assembler.sv | 40 ++++
 rtl/pmem_burst_bridge.sv | 160 ++++++++++++++++
 tb/tb_pmem_burst_bridge.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pmem_burst_bridge_pkg.sv
// pmem_bridge_pkg: shared constants, FSM state type and helpers for pmem_burst_bridge.
// Contents:
//   LINE_WIDTH / BEAT_WIDTH / ADDR_WIDTH  line, beat and byte-address widths
//   BEATS                                 beats per line (4)
//   BEAT_CNT_W                            beat counter width, log2(BEATS)
//   OFFSET_W / TAG_W                      byte-in-line offset width and line tag width
//   state_e                               bridge FSM states
//   line_align()                          clears the byte-in-line offset of an address
package pmem_bridge_pkg;

  localparam int unsigned LINE_WIDTH = 256;
  localparam int unsigned BEAT_WIDTH = 64;
  localparam int unsigned ADDR_WIDTH = 32;

  localparam int unsigned BEATS      = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned BEAT_CNT_W = $clog2(BEATS);
  localparam int unsigned OFFSET_W   = $clog2(LINE_WIDTH / 8);
  localparam int unsigned TAG_W      = ADDR_WIDTH - OFFSET_W;

  typedef enum logic [1:0] {
    StIdle,
    StRdBurst,
    StWrBurst,
    StResp
  } state_e;

  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ~ADDR_WIDTH'((LINE_WIDTH / 8) - 1);
  endfunction

endpackage

// File: rtl/pmem_burst_bridge_if.sv
// pmem_burst_bridge_if: bundles the 256-bit line side and the 64-bit burst side of the bridge.
// Line side   : pmem_read, pmem_write, pmem_address, pmem_wdata -> pmem_resp, pmem_rdata
// Burst side  : bmem_read, bmem_write, bmem_address, bmem_wdata -> bmem_resp, bmem_rdata
// Modports:
//   line_master  - requester (arbiter) view of the line side
//   line_slave   - bridge view of the line side
//   burst_master - bridge view of the burst side
//   burst_slave  - memory model/controller view of the burst side
interface pmem_burst_bridge_if;
  import pmem_bridge_pkg::*;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic                  pmem_resp;
  logic [LINE_WIDTH-1:0] pmem_rdata;

  logic                  bmem_read;
  logic                  bmem_write;
  logic [ADDR_WIDTH-1:0] bmem_address;
  logic [BEAT_WIDTH-1:0] bmem_wdata;
  logic [BEAT_WIDTH-1:0] bmem_rdata;
  logic                  bmem_resp;

  modport line_master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport line_slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );

  modport burst_master (
    output bmem_read, bmem_write, bmem_address, bmem_wdata,
    input  bmem_rdata, bmem_resp
  );

  modport burst_slave (
    input  bmem_read, bmem_write, bmem_address, bmem_wdata,
    output bmem_rdata, bmem_resp
  );

endinterface

// File: rtl/pmem_burst_bridge_line_assembler.sv
// line_assembler: owns the LINE_WIDTH working line register of the bridge.
// Ports:
//   clk, rst       clock, asynchronous active-high reset (clears the line)
//   i_beat_we      write i_beat_data into slot i_beat_idx (slot 0 = bits [63:0])
//   i_beat_idx     beat slot for both write-in and read-out
//   i_beat_data    beat to store
//   o_beat_data    contents of slot i_beat_idx
//   i_line_load    load the whole line from i_line_data (has priority over i_beat_we)
//   i_line_data    line to load
//   o_line         current line contents
module line_assembler
  import pmem_bridge_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_beat_we,
  input  logic [BEAT_CNT_W-1:0] i_beat_idx,
  input  logic [BEAT_WIDTH-1:0] i_beat_data,
  output logic [BEAT_WIDTH-1:0] o_beat_data,
  input  logic                  i_line_load,
  input  logic [LINE_WIDTH-1:0] i_line_data,
  output logic [LINE_WIDTH-1:0] o_line
);

  logic [BEATS-1:0][BEAT_WIDTH-1:0] r_line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line <= '0;
    end else if (i_line_load) begin
      r_line <= i_line_data;
    end else if (i_beat_we) begin
      r_line[i_beat_idx] <= i_beat_data;
    end
  end

  assign o_beat_data = r_line[i_beat_idx];
  assign o_line      = r_line;

endmodule

// File: rtl/pmem_burst_bridge.sv
// pmem_burst_bridge: turns each 256-bit line request into a 4-beat 64-bit burst and returns
// one pmem_resp per line.
// Ports:
//   clk      clock, all state changes on the rising edge
//   rst      asynchronous active-high reset; abandons any burst in flight
//   io_line  line side (line_slave): pmem_read/write/address/wdata in, pmem_resp/rdata out
//   io_burst burst side (burst_master): bmem_read/write/address/wdata out, bmem_resp/rdata in
// Optional feature: define PMEM_BRIDGE_LINEBUF_EN for a one-entry read line buffer that
// answers repeated reads of the same line without bmem traffic.
module pmem_burst_bridge
  import pmem_bridge_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  pmem_burst_bridge_if.line_slave   io_line,
  pmem_burst_bridge_if.burst_master io_burst
);

  state_e                           r_state;
  logic [BEAT_CNT_W-1:0]            r_beat_cnt;
  logic                             r_resp;
  logic [LINE_WIDTH-1:0]            r_rdata;
  logic                             r_bread;
  logic                             r_bwrite;
  logic [ADDR_WIDTH-1:0]            r_baddr;

  logic                             w_last_beat;
  logic                             w_asm_we;
  logic                             w_asm_load;
  logic                             w_rd_done;
  logic [BEAT_WIDTH-1:0]            w_asm_beat;
  logic [LINE_WIDTH-1:0]            w_asm_line;
  logic [BEATS-1:0][BEAT_WIDTH-1:0] w_line_merged;
  logic                             w_hit;
  logic [LINE_WIDTH-1:0]            w_buf_line;

  assign w_last_beat = (r_beat_cnt == BEAT_CNT_W'(BEATS - 1));
  assign w_asm_we    = (r_state == StRdBurst) && io_burst.bmem_resp;
  assign w_asm_load  = (r_state == StIdle) && io_line.pmem_write;
  assign w_rd_done   = w_asm_we && w_last_beat;

  line_assembler u_line_assembler (
    .clk         (clk),
    .rst         (rst),
    .i_beat_we   (w_asm_we),
    .i_beat_idx  (r_beat_cnt),
    .i_beat_data (io_burst.bmem_rdata),
    .o_beat_data (w_asm_beat),
    .i_line_load (w_asm_load),
    .i_line_data (io_line.pmem_wdata),
    .o_line      (w_asm_line)
  );

  // The last beat lands in the assembler on the same edge the line is published, so publish
  // the line with that beat merged in.
  always_comb begin
    w_line_merged             = w_asm_line;
    w_line_merged[r_beat_cnt] = io_burst.bmem_rdata;
  end

`ifdef PMEM_BRIDGE_LINEBUF_EN
  logic                  r_buf_valid;
  logic [TAG_W-1:0]      r_buf_tag;
  logic [LINE_WIDTH-1:0] r_buf_line;
  logic [TAG_W-1:0]      w_req_tag;

  assign w_req_tag  = io_line.pmem_address[ADDR_WIDTH-1:OFFSET_W];
  assign w_hit      = r_buf_valid && (r_buf_tag == w_req_tag);
  assign w_buf_line = r_buf_line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_buf_tag   <= '0;
      r_buf_line  <= '0;
    end else if (w_rd_done) begin
      r_buf_valid <= 1'b1;
      r_buf_tag   <= r_baddr[ADDR_WIDTH-1:OFFSET_W];
      r_buf_line  <= w_line_merged;
    end else if (w_asm_load && w_hit) begin
      // Keep the buffer coherent with a write to the buffered line.
      r_buf_line <= io_line.pmem_wdata;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_buf_line = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_beat_cnt <= '0;
      r_resp     <= 1'b0;
      r_rdata    <= '0;
      r_bread    <= 1'b0;
      r_bwrite   <= 1'b0;
      r_baddr    <= '0;
    end else begin
      r_resp <= 1'b0;
      case (r_state)
        StIdle: begin
          // Write wins when both requests are raised together.
          if (io_line.pmem_write) begin
            r_baddr  <= line_align(io_line.pmem_address);
            r_bwrite <= 1'b1;
            r_state  <= StWrBurst;
          end else if (io_line.pmem_read) begin
            if (w_hit) begin
              r_rdata <= w_buf_line;
              r_resp  <= 1'b1;
              r_state <= StResp;
            end else begin
              r_baddr <= line_align(io_line.pmem_address);
              r_bread <= 1'b1;
              r_state <= StRdBurst;
            end
          end
        end
        StRdBurst: begin
          if (io_burst.bmem_resp) begin
            r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
            if (w_last_beat) begin
              r_rdata <= w_line_merged;
              r_bread <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= StResp;
            end
          end
        end
        StWrBurst: begin
          if (io_burst.bmem_resp) begin
            r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
            if (w_last_beat) begin
              r_bwrite <= 1'b0;
              r_resp   <= 1'b1;
              r_state  <= StResp;
            end
          end
        end
        StResp: begin
          r_beat_cnt <= '0;
          r_state    <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign io_line.pmem_resp     = r_resp;
  assign io_line.pmem_rdata    = r_rdata;
  assign io_burst.bmem_read    = r_bread;
  assign io_burst.bmem_write   = r_bwrite;
  assign io_burst.bmem_address = r_baddr;
  // Drive zeros outside write bursts so the beat bus is quiet when idle.
  assign io_burst.bmem_wdata   = (r_state == StWrBurst) ? w_asm_beat : '0;

endmodule

// File: tb/tb_pmem_burst_bridge.sv
// tb_pmem_burst_bridge: directed, table-driven bench for pmem_burst_bridge.
// The bench plays both the line requester and a burst memory with a configurable number
// of stall cycles between beats. Cycle 1 is the cycle in which a request is first presented.
module tb_pmem_burst_bridge;

  logic clk;
  logic rst;

  pmem_burst_bridge_if bus ();

  pmem_burst_bridge dut (
    .clk      (clk),
    .rst      (rst),
    .io_line  (bus),
    .io_burst (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic            rd;
    logic            wr;
    logic [31:0]     addr;
    logic [255:0]    wdata;
    int              stall;
    logic [3:0][63:0] beats;
    logic [255:0]    exp_rdata;
    int              exp_cycle;
    logic [31:0]     exp_baddr;
    logic            exp_rd;
    logic            exp_wr;
  } vec_t;

  localparam logic [255:0] LineA = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] LineW = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                    64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [255:0] LineS = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                    64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
  localparam logic [255:0] LineD = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
                                    64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
  localparam logic [255:0] LineX = {64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
                                    64'h1234_5678_9ABC_DEF0, 64'h5678_5678_5678_5678};
  localparam logic [255:0] LineY = {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                                    64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001};
  localparam logic [255:0] LineF = {64'hCAFE_0000_0000_0040, 64'hCAFE_0000_0000_0030,
                                    64'hCAFE_0000_0000_0020, 64'hCAFE_0000_0000_0010};

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one line transaction starting at a negedge; returns after resp_cycle+3 or a
  // 60-cycle budget, leaving the bench at a negedge.
  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [255:0] wdata, input int stall,
                        input logic [3:0][63:0] beats,
                        output int resp_cycle, output int pulses, output logic [255:0] rdata,
                        output logic saw_rd, output logic saw_wr, output logic [31:0] baddr,
                        output logic [3:0][63:0] wbeats, output logic burst_tail);
    int beat;
    int gap;
    beat = 0;
    gap = 0;
    resp_cycle = 0;
    pulses = 0;
    rdata = '0;
    saw_rd = 1'b0;
    saw_wr = 1'b0;
    baddr = '0;
    wbeats = '0;
    burst_tail = 1'b0;
    bus.pmem_read = rd;
    bus.pmem_write = wr;
    bus.pmem_address = addr;
    bus.pmem_wdata = wdata;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      bus.bmem_resp = 1'b0;
      if (bus.bmem_read || bus.bmem_write) begin
        saw_rd |= bus.bmem_read;
        saw_wr |= bus.bmem_write;
        baddr = bus.bmem_address;
        if (gap == 0 && beat < 4) begin
          bus.bmem_resp = 1'b1;
          bus.bmem_rdata = beats[beat[1:0]];
          wbeats[beat[1:0]] = bus.bmem_wdata;
          beat++;
          gap = stall;
        end else if (gap > 0) begin
          gap--;
        end
      end
      if (bus.pmem_resp) begin
        pulses++;
        if (resp_cycle == 0) begin
          resp_cycle = cyc;
          rdata = bus.pmem_rdata;
          burst_tail = bus.bmem_read | bus.bmem_write;
        end
        bus.pmem_read = 1'b0;
        bus.pmem_write = 1'b0;
      end
      if (resp_cycle != 0 && cyc >= resp_cycle + 3) break;
      @(posedge clk);
      @(negedge clk);
    end
    bus.bmem_resp = 1'b0;
    bus.pmem_read = 1'b0;
    bus.pmem_write = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " pmem_resp"}, 256'(bus.pmem_resp), '0);
    check({tag, " pmem_rdata"}, bus.pmem_rdata, '0);
    check({tag, " bmem_read"}, 256'(bus.bmem_read), '0);
    check({tag, " bmem_write"}, 256'(bus.bmem_write), '0);
    check({tag, " bmem_address"}, 256'(bus.bmem_address), '0);
    check({tag, " bmem_wdata"}, 256'(bus.bmem_wdata), '0);
  endtask

  vec_t             vecs[6];
  int               rc;
  int               np;
  logic [255:0]     rdat;
  logic             srd;
  logic             swr;
  logic [31:0]      badr;
  logic [3:0][63:0] wb;
  logic             tail;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_1000, 256'h0, 0, LineA, LineA, 6, 32'h0000_1000,
                1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_2020, LineW, 0, 256'h0, LineA, 6, 32'h0000_2020,
                1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_3000, 256'h0, 3, LineS, LineS, 15, 32'h0000_3000,
                1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_105F, 256'h0, 1, LineD, LineD, 9, 32'h0000_1040,
                1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0080, LineX, 0, LineA, LineD, 6, 32'h0000_0080,
                1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_4000, LineY, 2, 256'h0, LineD, 12, 32'h0000_4000,
                1'b0, 1'b1};

    rst = 1'b1;
    bus.pmem_read = 1'b0;
    bus.pmem_write = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata = '0;
    bus.bmem_rdata = '0;
    bus.bmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].stall,
             vecs[i].beats, rc, np, rdat, srd, swr, badr, wb, tail);
      check($sformatf("v%0d resp_cycle", i), 256'(rc), 256'(vecs[i].exp_cycle));
      check($sformatf("v%0d resp_pulses", i), 256'(np), 256'(1));
      check($sformatf("v%0d pmem_rdata", i), rdat, vecs[i].exp_rdata);
      check($sformatf("v%0d bmem_address", i), 256'(badr), 256'(vecs[i].exp_baddr));
      check($sformatf("v%0d saw_bmem_read", i), 256'(srd), 256'(vecs[i].exp_rd));
      check($sformatf("v%0d saw_bmem_write", i), 256'(swr), 256'(vecs[i].exp_wr));
      check($sformatf("v%0d burst_tail", i), 256'(tail), '0);
      if (vecs[i].exp_wr) begin
        check($sformatf("v%0d wdata_beats", i), wb, vecs[i].wdata);
      end
    end

    // Reset after two beats of a read: outputs clear asynchronously, then a fresh read works.
    bus.pmem_read = 1'b1;
    bus.pmem_address = 32'h0000_1000;
    @(posedge clk);
    @(negedge clk);
    check("midrst burst_started", 256'(bus.bmem_read), 256'(1));
    bus.bmem_resp = 1'b1;
    bus.bmem_rdata = 64'h9999_9999_9999_9999;
    @(posedge clk);
    @(negedge clk);
    bus.bmem_rdata = 64'hAAAA_0000_AAAA_0000;
    @(posedge clk);
    @(negedge clk);
    bus.bmem_resp = 1'b0;
    bus.pmem_read = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_txn(1'b1, 1'b0, 32'h0000_0040, 256'h0, 0, LineF, rc, np, rdat, srd, swr, badr, wb,
           tail);
    check("postrst resp_cycle", 256'(rc), 256'(6));
    check("postrst resp_pulses", 256'(np), 256'(1));
    check("postrst pmem_rdata", rdat, LineF);
    check("postrst bmem_address", 256'(badr), 256'(32'h0000_0040));

`ifdef PMEM_BRIDGE_LINEBUF_EN
    do_txn(1'b1, 1'b0, 32'h0000_0100, 256'h0, 0, LineS, rc, np, rdat, srd, swr, badr, wb,
           tail);
    check("lb miss resp_cycle", 256'(rc), 256'(6));
    check("lb miss pmem_rdata", rdat, LineS);
    do_txn(1'b1, 1'b0, 32'h0000_0100, 256'h0, 0, LineA, rc, np, rdat, srd, swr, badr, wb,
           tail);
    check("lb hit resp_cycle", 256'(rc), 256'(2));
    check("lb hit no_bmem_read", 256'(srd), '0);
    check("lb hit pmem_rdata", rdat, LineS);
    do_txn(1'b0, 1'b1, 32'h0000_0100, LineW, 0, 256'h0, rc, np, rdat, srd, swr, badr, wb,
           tail);
    check("lb write resp_cycle", 256'(rc), 256'(6));
    check("lb write burst", 256'(swr), 256'(1));
    check("lb write wdata_beats", wb, LineW);
    do_txn(1'b1, 1'b0, 32'h0000_0100, 256'h0, 0, LineA, rc, np, rdat, srd, swr, badr, wb,
           tail);
    check("lb rehit resp_cycle", 256'(rc), 256'(2));
    check("lb rehit no_bmem_read", 256'(srd), '0);
    check("lb rehit pmem_rdata", rdat, LineW);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
